// File: rtl/menu_char_draw.sv
// menu_char_draw
// Overlays a 16 x 16 character text field (8x16-pixel cells, 128 x 256 pixels)
// onto a VGA pixel stream at (X_POS, Y_POS).
//
// The text ROM and font ROM live outside this block.
// - Cycle 1: the text-ROM address is issued on char_xy.
// - Cycle 2: the glyph row index is issued on char_line, together with the
//   returned char_code. The font ROM is addressed externally with
//   {char_code, char_line}.
// - Cycle 3: the selected glyph row comes back on char_pixels.
// - Cycle 4: the recoloured pixel leaves on rgb_out. Every other VGA output
//   is the matching input delayed by exactly 4 clocks.
//
// Ports
//   clk, rst            pixel clock, asynchronous active-high reset
//   hcount_in..rgb_in   incoming VGA stream (counters, strobes, background)
//   char_xy             text-ROM address {row[3:0], col[3:0]}
//   char_code           text-ROM data (consumed by the external font ROM)
//   char_line           glyph row index for the font ROM
//   char_pixels         glyph row from the font ROM, bit 7 = leftmost pixel
//   hcount_out..rgb_out VGA stream delayed by 4 clocks, with text drawn in

module menu_char_draw #(
   parameter logic [10:0] X_POS    = 11'd100,
   parameter logic [10:0] Y_POS    = 11'd100,
   parameter logic [11:0] FG_COLOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic [7:0]  char_xy,
   input  logic [6:0]  char_code,
   output logic [3:0]  char_line,
   input  logic [7:0]  char_pixels,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        hblnk;
      logic        vsync;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_t;

   vga_t        vgaIn;
   vga_t        vga_q1, vga_q2, vga_q3;
   vga_t        vgaOut_d, vgaOut_q;
   logic [6:0]  relX;
   logic [7:0]  relY;
   logic        inArea;
   logic [7:0]  charXy_d, charXy_q;
   logic [3:0]  charLine_q;
   logic [3:0]  relYLow_q1;
   logic [2:0]  relXLow_q1, relXLow_q2, relXLow_q3;
   logic        inArea_q1, inArea_q2, inArea_q3;
   logic [2:0]  pixelIndex;
   logic        lit;
   logic        unusedCharCode;

   // char_code only matters to the external font ROM. It is carried here
   // so that the text/font handshake stays documented on one port list.
   assign unusedCharCode = ^char_code;

   assign vgaIn = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in,
                    rgb: rgb_in};

   // Field-relative position. Only the low bits feed the cell address and
   // the glyph indexing, and low bits of a difference depend only on low
   // bits of the operands. The field test uses 12-bit compares, so a field
   // that runs past the 11-bit counter range cannot wrap around and light
   // pixels near the origin.
   always_comb begin
      relX   = hcount_in[6:0] - X_POS[6:0];
      relY   = vcount_in[7:0] - Y_POS[7:0];
      inArea = ({1'b0, hcount_in} >= {1'b0, X_POS})
            && ({1'b0, hcount_in} <  ({1'b0, X_POS} + 12'd128))
            && ({1'b0, vcount_in} >= {1'b0, Y_POS})
            && ({1'b0, vcount_in} <  ({1'b0, Y_POS} + 12'd256));
      charXy_d = inArea ? {relY[7:4], relX[6:3]} : 8'h00;
   end

   // Pixel select happens one stage before the output register. The glyph
   // row arrives here aligned with the 3-clock-delayed column and field flag.
   always_comb begin
      pixelIndex = 3'd7 - relXLow_q3;
      lit        = inArea_q3 && char_pixels[pixelIndex];
      vgaOut_d   = vga_q3;
      if (lit && !vga_q3.hblnk && !vga_q3.vblnk) begin
         vgaOut_d.rgb = FG_COLOR;
      end
   end

   // The whole pipeline clears together on reset, so no pixel that was in
   // flight when reset arrived can reappear after it is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         charXy_q   <= '0;
         charLine_q <= '0;
         relYLow_q1 <= '0;
         relXLow_q1 <= '0;
         relXLow_q2 <= '0;
         relXLow_q3 <= '0;
         inArea_q1  <= 1'b0;
         inArea_q2  <= 1'b0;
         inArea_q3  <= 1'b0;
         vga_q1     <= '0;
         vga_q2     <= '0;
         vga_q3     <= '0;
         vgaOut_q   <= '0;
      end else begin
         charXy_q   <= charXy_d;
         relYLow_q1 <= relY[3:0];
         charLine_q <= relYLow_q1;
         relXLow_q1 <= relX[2:0];
         relXLow_q2 <= relXLow_q1;
         relXLow_q3 <= relXLow_q2;
         inArea_q1  <= inArea;
         inArea_q2  <= inArea_q1;
         inArea_q3  <= inArea_q2;
         vga_q1     <= vgaIn;
         vga_q2     <= vga_q1;
         vga_q3     <= vga_q2;
         vgaOut_q   <= vgaOut_d;
      end
   end

   assign char_xy    = charXy_q;
   assign char_line  = charLine_q;
   assign hcount_out = vgaOut_q.hcount;
   assign vcount_out = vgaOut_q.vcount;
   assign hsync_out  = vgaOut_q.hsync;
   assign hblnk_out  = vgaOut_q.hblnk;
   assign vsync_out  = vgaOut_q.vsync;
   assign vblnk_out  = vgaOut_q.vblnk;
   assign rgb_out    = vgaOut_q.rgb;

endmodule

// File: tb/tb_menu_char_draw.sv
// Bench for menu_char_draw.
// The driver pushes the expected responses into three queues as each vector
// is applied:
//   char_xy    due 1 clock later
//   char_line  due 2 clocks later
//   VGA output due 4 clocks later
// A negedge monitor pops and compares each entry on the cycle it falls due.
// The text ROM and font ROM are modelled as registered memories. The font
// returns 8'h80 or 8'hFF for every code, depending on fontMode.

module tb_menu_char_draw;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] hcount_in = '0;
   logic [10:0] vcount_in = '0;
   logic        hsync_in = 1'b0;
   logic        hblnk_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic        vblnk_in = 1'b0;
   logic [11:0] rgb_in = '0;
   logic [7:0]  char_xy;
   logic [6:0]  char_code = '0;
   logic [3:0]  char_line;
   logic [7:0]  char_pixels = '0;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
   logic [11:0] rgb_out;

   typedef struct {
      int          due;
      logic [7:0]  val;
   } smallItem_t;

   typedef struct {
      int          due;
      logic [10:0] h, v;
      logic        hs, hb, vs, vb;
      logic [11:0] rgb;
   } outItem_t;

   smallItem_t xyQ[$];
   smallItem_t lineQ[$];
   outItem_t   outQ[$];
   smallItem_t smallIt;
   outItem_t   outIt;

   int   cycleCount = 0;
   int   checkCount = 0;
   int   passCount  = 0;
   logic fontMode   = 1'b0;

   menu_char_draw #(.X_POS(11'd100), .Y_POS(11'd100), .FG_COLOR(12'hFFF)) dut (
      .clk(clk), .rst(rst),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .vsync_in(vsync_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in),
      .char_xy(char_xy), .char_code(char_code),
      .char_line(char_line), .char_pixels(char_pixels),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .hblnk_out(hblnk_out),
      .vsync_out(vsync_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Registered ROM models, one clock each.
   always @(posedge clk) begin
      char_code   <= char_xy[6:0];
      char_pixels <= fontMode ? 8'hFF : 8'h80;
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                    name, act, exp, cycleCount);
   endtask

   // Sets the inputs and pushes the expectations for the current cycle.
   task automatic pushVector(input int h, input int v, input logic hs,
                             input logic hb, input logic vs, input logic vb,
                             input logic [11:0] rgb);
      logic [10:0] rx, ry;
      logic [7:0]  fontRow;
      logic        inField;
      logic        bitLit;
      hcount_in = 11'(h); vcount_in = 11'(v);
      hsync_in = hs; hblnk_in = hb; vsync_in = vs; vblnk_in = vb;
      rgb_in = rgb;
      rx = 11'(h) - 11'd100;
      ry = 11'(v) - 11'd100;
      inField = (h >= 100) && (h < 228) && (v >= 100) && (v < 356);
      fontRow = fontMode ? 8'hFF : 8'h80;
      bitLit  = fontRow[3'd7 - rx[2:0]];
      xyQ.push_back('{due: cycleCount + 1,
                      val: inField ? {ry[7:4], rx[6:3]} : 8'h00});
      lineQ.push_back('{due: cycleCount + 2, val: {4'h0, ry[3:0]}});
      outQ.push_back('{due: cycleCount + 4, h: 11'(h), v: 11'(v),
                       hs: hs, hb: hb, vs: vs, vb: vb,
                       rgb: (inField && !hb && !vb && bitLit) ? 12'hFFF : rgb});
   endtask

   task automatic applyStimulus(input int h, input int v, input logic hs,
                                input logic hb, input logic vs, input logic vb,
                                input logic [11:0] rgb);
      @(posedge clk); #1;
      pushVector(h, v, hs, hb, vs, vb, rgb);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_char_xy"}, 32'(char_xy), 32'h0);
      checkOutput({tag, "_char_line"}, 32'(char_line), 32'h0);
      checkOutput({tag, "_hcount"}, 32'(hcount_out), 32'h0);
      checkOutput({tag, "_vcount"}, 32'(vcount_out), 32'h0);
      checkOutput({tag, "_strobes"},
                  32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'h0);
      checkOutput({tag, "_rgb"}, 32'(rgb_out), 32'h0);
   endtask

   // Monitor: compares every queued expectation on the cycle it is due.
   always @(negedge clk) begin
      if (!rst) begin
         while (xyQ.size() > 0 && xyQ[0].due < cycleCount) begin
            smallIt = xyQ.pop_front();
            checkCount++;
            $display("[TB] FAIL xy_missed: due %0d, now %0d", smallIt.due, cycleCount);
         end
         if (xyQ.size() > 0 && xyQ[0].due == cycleCount) begin
            smallIt = xyQ.pop_front();
            checkOutput("char_xy", 32'(char_xy), 32'(smallIt.val));
         end
         if (lineQ.size() > 0 && lineQ[0].due == cycleCount) begin
            smallIt = lineQ.pop_front();
            checkOutput("char_line", 32'(char_line), 32'(smallIt.val));
         end
         if (outQ.size() > 0 && outQ[0].due == cycleCount) begin
            outIt = outQ.pop_front();
            checkOutput("hcount_out", 32'(hcount_out), 32'(outIt.h));
            checkOutput("vcount_out", 32'(vcount_out), 32'(outIt.v));
            checkOutput("strobes_out",
                        32'({hsync_out, hblnk_out, vsync_out, vblnk_out}),
                        32'({outIt.hs, outIt.hb, outIt.vs, outIt.vb}));
            checkOutput("rgb_out", 32'(rgb_out), 32'(outIt.rgb));
         end
      end
   end

   initial begin
      // Power-on reset
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("por");
      rst = 1'b0;

      // Font row 8'h80: only rel_x%8==0 lights
      applyStimulus(100, 100, 1, 0, 0, 0, 12'h000);
      applyStimulus(101, 100, 0, 0, 1, 0, 12'h000);
      applyStimulus(108, 116, 1, 0, 1, 0, 12'h000);
      applyStimulus(227, 355, 0, 0, 0, 0, 12'h000);
      applyStimulus(220, 355, 1, 0, 0, 0, 12'h000);
      applyStimulus(228, 355, 0, 0, 1, 0, 12'h7E1);
      applyStimulus(224, 356, 1, 0, 0, 0, 12'h3C3);
      applyStimulus( 99, 100, 0, 0, 0, 0, 12'h0F0);
      applyStimulus(100,  99, 1, 0, 1, 0, 12'h00F);
      applyStimulus(150, 200, 0, 0, 0, 0, 12'h5A3);
      applyStimulus(148, 200, 0, 0, 0, 0, 12'h5A3);

      // Blanking inside the field leaves the background untouched
      applyStimulus(100, 100, 1, 1, 0, 0, 12'h123);
      applyStimulus(108, 100, 0, 0, 1, 1, 12'h456);
      applyStimulus(108, 100, 0, 0, 0, 0, 12'h456);

      // Out-of-field padding before the font row changes
      repeat (4) applyStimulus(0, 0, 0, 1, 0, 1, 12'h000);
      fontMode = 1'b1;

      // Font row 8'hFF: edges and just-outside pixels
      applyStimulus( 99, 150, 0, 0, 0, 0, 12'hABC);
      applyStimulus(100,  99, 0, 0, 0, 0, 12'hABC);
      applyStimulus(227, 355, 1, 0, 1, 0, 12'h000);
      applyStimulus(228, 355, 0, 0, 0, 0, 12'h111);
      applyStimulus(227, 356, 0, 0, 0, 0, 12'h222);
      applyStimulus(130, 140, 0, 0, 0, 0, 12'h333);
      repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 12'h000);
      fontMode = 1'b0;

      // Fill the pipeline with lit pixels, then reset mid-field
      repeat (5) applyStimulus(108, 117, 1, 0, 1, 0, 12'h000);
      @(posedge clk); #1;
      rst = 1'b1;
      xyQ.delete(); lineQ.delete(); outQ.delete();
      #1;
      checkAllZero("midrst");
      @(posedge clk);
      @(posedge clk); #1;
      checkAllZero("midrst_hold");
      rst = 1'b0;

      // The first three outputs after release carry the cleared pipeline
      for (int k = 1; k <= 3; k++) begin
         outQ.push_back('{due: cycleCount + k, h: 11'd0, v: 11'd0, hs: 1'b0,
                          hb: 1'b0, vs: 1'b0, vb: 1'b0, rgb: 12'h000});
      end
      pushVector(100, 100, 1, 0, 1, 0, 12'h000);
      applyStimulus(108, 100, 1, 0, 1, 0, 12'h000);
      applyStimulus(109, 100, 0, 0, 0, 0, 12'h000);

      // Drain with a bounded wait
      for (int i = 0; i < 20; i++) begin
         if (xyQ.size() == 0 && lineQ.size() == 0 && outQ.size() == 0) break;
         @(posedge clk);
      end
      if (xyQ.size() != 0 || lineQ.size() != 0 || outQ.size() != 0) begin
         checkCount++;
         $display("[TB] FAIL drain_timeout: pending %0d/%0d/%0d, expected 0",
                  xyQ.size(), lineQ.size(), outQ.size());
      end
      @(negedge clk);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
